instruction_buffer: RTL and testbench

Instruction FIFO and issue sequencer placed directly upstream of the video processor. Buffers 64-bit instructions (dataA/dataB pairs) written by the CPU-side interface. Presents each one to the processor with a single-cycle `out_clk_en` strobe, and only while the screen is not being printed. Paces issues so the processor's decode/write path finishes before the next instruction arrives.

---
 rtl/instruction_buffer.sv | 133 +++++++++++++
 tb/tb_instruction_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_buffer.sv
// Instruction FIFO feeding the video processor: buffers 64-bit {A,B} instructions and
// issues them one at a time with a single-cycle clock-enable strobe, paced and print-gated.
module instruction_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4,
    parameter int ISSUE_GAP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          in_dataA,
    input  logic [31:0]          in_dataB,
    input  logic                 wr_en,
    input  logic                 printtingScreen,
    output logic [31:0]          out_dataA,
    output logic [31:0]          out_dataB,
    output logic                 out_clk_en,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 busy
);

    localparam int                 GAP_W    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [63:0]          r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_overflow;
    state_t               r_state;
    logic [GAP_W-1:0]     r_gap;
    logic [31:0]          r_out_a;
    logic [31:0]          r_out_b;
    logic                 r_clk_en;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_issue;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == {(ADDR_BITS + 1){1'b0}});
    // A write landing on a full FIFO is dropped even if an issue frees a slot that same edge.
    assign w_wr_acc = wr_en & ~w_full;
    assign w_issue  = (r_state == S_ISSUE);

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {in_dataA, in_dataB};
        end
    end

    // Write pointer, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= {ADDR_BITS{1'b0}};
            r_count    <= {(ADDR_BITS + 1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_wr_acc, w_issue})
                2'b10:   r_count <= r_count + (ADDR_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue sequencer: head data and strobe are registered on the IDLE->ISSUE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= {ADDR_BITS{1'b0}};
            r_gap    <= {GAP_W{1'b0}};
            r_out_a  <= 32'd0;
            r_out_b  <= 32'd0;
            r_clk_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && !printtingScreen) begin
                        r_state  <= S_ISSUE;
                        r_clk_en <= 1'b1;
                        r_out_a  <= r_mem[r_rd_ptr][63:32];
                        r_out_b  <= r_mem[r_rd_ptr][31:0];
                    end
                end
                S_ISSUE: begin
                    r_clk_en <= 1'b0;
                    r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
                    r_gap    <= GAP_LOAD;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_gap == {GAP_W{1'b0}}) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_clk_en <= 1'b0;
                end
            endcase
        end
    end

    assign out_dataA  = r_out_a;
    assign out_dataB  = r_out_b;
    assign out_clk_en = r_clk_en;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed self-checking bench for instruction_buffer (DEPTH=16, ISSUE_GAP=4).
module tb_instruction_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_dataA = 32'd0;
    logic [31:0] in_dataB = 32'd0;
    logic        wr_en = 1'b0;
    logic        printtingScreen = 1'b0;
    logic [31:0] out_dataA;
    logic [31:0] out_dataB;
    logic        out_clk_en;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0;
    int n_both = 0;
    logic cnt_chk_en = 1'b0;
    logic       pre_acc = 1'b0;
    logic       pre_iss = 1'b0;
    logic [4:0] pre_cnt = 5'd0;

    int          q_cyc[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    instruction_buffer #(.DEPTH(16), .ADDR_BITS(4), .ISSUE_GAP(4)) dut (
        .clk(clk), .reset(reset), .in_dataA(in_dataA), .in_dataB(in_dataB),
        .wr_en(wr_en), .printtingScreen(printtingScreen),
        .out_dataA(out_dataA), .out_dataB(out_dataB), .out_clk_en(out_clk_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        pre_acc <= wr_en && !full;
        pre_iss <= out_clk_en;
        pre_cnt <= count;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe recorder plus the occupancy rule: +1 write, -1 issue, hold when both.
    always @(negedge clk) begin
        if (out_clk_en) begin
            q_cyc.push_back(cyc);
            q_a.push_back(out_dataA);
            q_b.push_back(out_dataB);
        end
        if (cnt_chk_en && !reset) begin
            chk("cnt_rule", 64'(count), 64'(int'(pre_cnt) + int'(pre_acc) - int'(pre_iss)));
            if (pre_acc && pre_iss) n_both++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] b);
        in_dataA = a;
        in_dataB = b;
        wr_en    = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    task automatic clr_q();
        q_cyc.delete();
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        // reset values
        tick(2);
        chk("rst_a", 64'(out_dataA), 64'h0);
        chk("rst_b", 64'(out_dataB), 64'h0);
        chk("rst_en", 64'(out_clk_en), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        tick(1);

        // single write, 2-cycle latency, busy through the gap
        wr(32'h11, 32'h22);
        chk("s_cnt1", 64'(count), 64'h1);
        chk("s_en_e0", 64'(out_clk_en), 64'h0);
        tick(1);
        chk("s_en", 64'(out_clk_en), 64'h1);
        chk("s_a", 64'(out_dataA), 64'h11);
        chk("s_b", 64'(out_dataB), 64'h22);
        tick(1);
        chk("s_en_off", 64'(out_clk_en), 64'h0);
        chk("s_cnt0", 64'(count), 64'h0);
        chk("s_empty", 64'(empty), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("s_busy_wait", 64'(busy), 64'h1);
        end
        tick(1);
        chk("s_idle", 64'(busy), 64'h0);

        // burst of 5
        clr_q();
        wr(32'h101, 32'h201);
        e0 = cyc;
        for (int i = 2; i <= 5; i++) wr(32'h100 + 32'(i), 32'h200 + 32'(i));
        tick(40);
        chk("b_n", 64'(q_a.size()), 64'd5);
        if (q_cyc.size() > 0) chk("b_lat", 64'(q_cyc[0] - e0), 64'd1);
        for (int i = 0; i < q_a.size() && i < 5; i++) begin
            chk("b_a", 64'(q_a[i]), 64'h101 + 64'(i));
            chk("b_b", 64'(q_b[i]), 64'h201 + 64'(i));
            if (i > 0) chk("b_period", 64'(q_cyc[i] - q_cyc[i-1]), 64'd6);
        end
        chk("b_cnt", 64'(count), 64'h0);

        // print blocking
        clr_q();
        printtingScreen = 1'b1;
        for (int i = 1; i <= 3; i++) wr(32'h300 + 32'(i), 32'h400 + 32'(i));
        tick(5);
        chk("p_nostrobe", 64'(q_a.size()), 64'd0);
        chk("p_cnt", 64'(count), 64'd3);
        printtingScreen = 1'b0;
        tick(1);
        chk("p_en", 64'(out_clk_en), 64'h1);
        chk("p_a", 64'(out_dataA), 64'h301);
        tick(20);
        chk("p_n", 64'(q_a.size()), 64'd3);
        for (int i = 0; i < q_a.size() && i < 3; i++)
            chk("p_b", 64'(q_b[i]), 64'h401 + 64'(i));

        // full / overflow
        clr_q();
        printtingScreen = 1'b1;
        for (int i = 1; i <= 16; i++) wr(32'h500 + 32'(i), 32'h600 + 32'(i));
        chk("f_full", 64'(full), 64'h1);
        chk("f_ovf0", 64'(overflow), 64'h0);
        chk("f_cnt16", 64'(count), 64'd16);
        wr(32'h511, 32'h611);
        chk("f_ovf1", 64'(overflow), 64'h1);
        chk("f_cnt_hold", 64'(count), 64'd16);
        printtingScreen = 1'b0;
        tick(110);
        chk("f_n", 64'(q_a.size()), 64'd16);
        for (int i = 0; i < q_a.size() && i < 16; i++)
            chk("f_a", 64'(q_a[i]), 64'h501 + 64'(i));
        chk("f_empty", 64'(empty), 64'h1);
        chk("f_ovf_sticky", 64'(overflow), 64'h1);

        // wrap with writes overlapping issues
        clr_q();
        cnt_chk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(32'h700 + 32'(i), 32'h800 + 32'(i));
            tick(4);
        end
        tick(150);
        cnt_chk_en = 1'b0;
        chk("w_both_seen", 64'(n_both > 0), 64'h1);
        chk("w_n", 64'(q_a.size()), 64'd20);
        for (int i = 0; i < q_a.size() && i < 20; i++) begin
            chk("w_a", 64'(q_a[i]), 64'h700 + 64'(i));
            chk("w_b", 64'(q_b[i]), 64'h800 + 64'(i));
        end
        chk("w_cnt", 64'(count), 64'h0);

        // async reset during WAIT
        wr(32'hB01, 32'hC01);
        wr(32'hB02, 32'hC02);
        wr(32'hB03, 32'hC03);
        chk("r_busy", 64'(busy), 64'h1);
        chk("r_cnt2", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("r_a", 64'(out_dataA), 64'h0);
        chk("r_b", 64'(out_dataB), 64'h0);
        chk("r_en", 64'(out_clk_en), 64'h0);
        chk("r_cnt", 64'(count), 64'h0);
        chk("r_empty", 64'(empty), 64'h1);
        chk("r_ovf", 64'(overflow), 64'h0);
        chk("r_busy0", 64'(busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        chk("r_lost", 64'(count), 64'h0);
        wr(32'hC1, 32'hD1);
        chk("r2_en0", 64'(out_clk_en), 64'h0);
        tick(1);
        chk("r2_en", 64'(out_clk_en), 64'h1);
        chk("r2_a", 64'(out_dataA), 64'hC1);
        chk("r2_b", 64'(out_dataB), 64'hD1);

        // async reset during ISSUE drops the strobe at once
        tick(8);
        wr(32'hE1, 32'hF1);
        tick(1);
        chk("ri_en1", 64'(out_clk_en), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("ri_en0", 64'(out_clk_en), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
